// File: rtl/uop_pkg.sv
// Opcode encoding shared by custom-instruction decode, the sequence issuer and the execute stage.
package uop_pkg;

    typedef enum logic [3:0] {
        OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR,
        OP_INC, OP_DEC, OP_MOV, OP_CMP
    } op_t;

endpackage

// File: rtl/uop_seq_issuer.sv
// Streams runtime-programmable uop sequences from a writable table, one uop per handshake,
// inserting a one-cycle bubble after every step flagged as a flip-flop boundary.
module uop_seq_issuer
    import uop_pkg::*;
#(
    parameter int unsigned N_CASE  = 4,
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned TAG_W   = 4,
    localparam int unsigned CASE_W = (N_CASE > 1) ? $clog2(N_CASE) : 1,
    localparam int unsigned STEP_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
    localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cfg_len_we_i,
    input  logic              cfg_step_we_i,
    input  logic [CASE_W-1:0] cfg_case_i,
    input  logic [STEP_W-1:0] cfg_step_i,
    input  logic [LEN_W-1:0]  cfg_len_i,
    input  op_t               cfg_op_i,
    input  logic [31:0]       cfg_imm_i,
    input  logic              cfg_use_imm_i,
    input  logic              cfg_ff_i,
    output logic              cfg_err_o,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [CASE_W-1:0] req_case_i,
    input  logic [TAG_W-1:0]  req_tag_i,
    output logic              req_err_o,
    output logic              uop_valid_o,
    input  logic              uop_ready_i,
    output op_t               uop_op_o,
    output logic [31:0]       uop_imm_o,
    output logic              uop_use_imm_o,
    output logic [STEP_W-1:0] uop_step_o,
    output logic              uop_first_o,
    output logic              uop_last_o,
    output logic [TAG_W-1:0]  uop_tag_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {StIdle, StIssue, StBubble} state_t;

    state_t            state_q;
    logic [LEN_W-1:0]  len_q     [N_CASE];
    op_t               op_q      [N_CASE][MAX_LEN];
    logic [31:0]       imm_q     [N_CASE][MAX_LEN];
    logic              use_imm_q [N_CASE][MAX_LEN];
    logic              ff_q      [N_CASE][MAX_LEN];

    logic [CASE_W-1:0] case_q;
    logic [TAG_W-1:0]  tag_q;
    logic [LEN_W-1:0]  seq_len_q;
    logic              uop_valid_q, cfg_err_q, req_err_q;
    op_t               uop_op_q;
    logic [31:0]       uop_imm_q;
    logic              uop_use_imm_q, uop_ff_q, uop_first_q, uop_last_q;
    logic [STEP_W-1:0] uop_step_q;

    logic              busy, slot_locked, len_wr, step_wr, cfg_rej, last_nxt;
    logic [STEP_W-1:0] step_nxt;
    logic [LEN_W-1:0]  req_len;

    always_comb begin
        busy        = (state_q != StIdle);
        // The slot feeding an in-flight sequence is frozen until it completes.
        slot_locked = busy && (cfg_case_i == case_q);
        len_wr      = cfg_len_we_i && !slot_locked && (cfg_len_i <= LEN_W'(MAX_LEN));
        step_wr     = cfg_step_we_i && !slot_locked;
        cfg_rej     = (cfg_len_we_i && !len_wr) || (cfg_step_we_i && !step_wr);
        step_nxt    = uop_step_q + STEP_W'(1);
        last_nxt    = (LEN_W'(step_nxt) + LEN_W'(1)) == seq_len_q;
        req_len     = len_q[req_case_i];
    end

    always_ff @(posedge clk_i) begin
        if (step_wr) begin
            op_q[cfg_case_i][cfg_step_i]      <= cfg_op_i;
            imm_q[cfg_case_i][cfg_step_i]     <= cfg_imm_i;
            use_imm_q[cfg_case_i][cfg_step_i] <= cfg_use_imm_i;
            ff_q[cfg_case_i][cfg_step_i]      <= cfg_ff_i;
        end
    end

    // Output fields are loaded one cycle ahead from the table, so a request accepted in the
    // same cycle as a write to its slot still presents the pre-write step 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            uop_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            req_err_q   <= 1'b0;
            for (int unsigned i = 0; i < N_CASE; i++) begin
                len_q[i] <= '0;
            end
        end else begin
            cfg_err_q <= cfg_rej;
            req_err_q <= 1'b0;
            if (len_wr) begin
                len_q[cfg_case_i] <= cfg_len_i;
            end
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        case_q    <= req_case_i;
                        tag_q     <= req_tag_i;
                        seq_len_q <= req_len;
                        if (req_len == '0) begin
                            req_err_q <= 1'b1;
                        end else begin
                            state_q       <= StIssue;
                            uop_valid_q   <= 1'b1;
                            uop_step_q    <= '0;
                            uop_first_q   <= 1'b1;
                            uop_last_q    <= (req_len == LEN_W'(1));
                            uop_op_q      <= op_q[req_case_i][0];
                            uop_imm_q     <= imm_q[req_case_i][0];
                            uop_use_imm_q <= use_imm_q[req_case_i][0];
                            uop_ff_q      <= ff_q[req_case_i][0];
                        end
                    end
                end
                StIssue: begin
                    if (uop_ready_i) begin
                        if (uop_last_q) begin
                            state_q     <= StIdle;
                            uop_valid_q <= 1'b0;
                        end else begin
                            uop_step_q    <= step_nxt;
                            uop_first_q   <= 1'b0;
                            uop_last_q    <= last_nxt;
                            uop_op_q      <= op_q[case_q][step_nxt];
                            uop_imm_q     <= imm_q[case_q][step_nxt];
                            uop_use_imm_q <= use_imm_q[case_q][step_nxt];
                            uop_ff_q      <= ff_q[case_q][step_nxt];
                            if (uop_ff_q) begin
                                state_q     <= StBubble;
                                uop_valid_q <= 1'b0;
                            end
                        end
                    end
                end
                StBubble: begin
                    state_q     <= StIssue;
                    uop_valid_q <= 1'b1;
                end
                default: begin
                    state_q     <= StIdle;
                    uop_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o   = (state_q == StIdle) && !rst_i;
    assign busy_o        = busy;
    assign cfg_err_o     = cfg_err_q;
    assign req_err_o     = req_err_q;
    assign uop_valid_o   = uop_valid_q;
    assign uop_op_o      = uop_op_q;
    assign uop_imm_o     = uop_imm_q;
    assign uop_use_imm_o = uop_use_imm_q;
    assign uop_step_o    = uop_step_q;
    assign uop_first_o   = uop_first_q;
    assign uop_last_o    = uop_last_q;
    assign uop_tag_o     = tag_q;

endmodule

// File: tb/tb_uop_seq_issuer.sv
// Self-checking bench for uop_seq_issuer: directed vector table, hand-written corner sequences
// and randomized traffic checked against a queue-based model of the expected uop stream.
module tb_uop_seq_issuer;
    import uop_pkg::*;

    localparam int N_CASE  = 4;
    localparam int MAX_LEN = 8;
    localparam int TAG_W   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_len_we, cfg_step_we;
    logic [1:0]  cfg_case;
    logic [2:0]  cfg_step;
    logic [3:0]  cfg_len;
    op_t         cfg_op;
    logic [31:0] cfg_imm;
    logic        cfg_use_imm, cfg_ff, cfg_err;
    logic        req_valid, req_ready, req_err;
    logic [1:0]  req_case;
    logic [3:0]  req_tag;
    logic        uop_valid, uop_ready;
    op_t         uop_op;
    logic [31:0] uop_imm;
    logic        uop_use_imm, uop_first, uop_last, busy;
    logic [2:0]  uop_step;
    logic [3:0]  uop_tag;

    uop_seq_issuer #(.N_CASE(N_CASE), .MAX_LEN(MAX_LEN), .TAG_W(TAG_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .cfg_len_we_i(cfg_len_we), .cfg_step_we_i(cfg_step_we), .cfg_case_i(cfg_case),
        .cfg_step_i(cfg_step), .cfg_len_i(cfg_len), .cfg_op_i(cfg_op), .cfg_imm_i(cfg_imm),
        .cfg_use_imm_i(cfg_use_imm), .cfg_ff_i(cfg_ff), .cfg_err_o(cfg_err),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_case_i(req_case),
        .req_tag_i(req_tag), .req_err_o(req_err),
        .uop_valid_o(uop_valid), .uop_ready_i(uop_ready), .uop_op_o(uop_op),
        .uop_imm_o(uop_imm), .uop_use_imm_o(uop_use_imm), .uop_step_o(uop_step),
        .uop_first_o(uop_first), .uop_last_o(uop_last), .uop_tag_o(uop_tag), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_len   [N_CASE];
    logic [3:0]  m_op    [N_CASE][MAX_LEN];
    logic [31:0] m_imm   [N_CASE][MAX_LEN];
    bit          m_use   [N_CASE][MAX_LEN];
    bit          m_ff    [N_CASE][MAX_LEN];

    typedef struct {
        int slot; int len; int ff; int tag; int op0; int op_inc; int exp_span;
    } vec_t;
    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wr_len(input int slot, input int len);
        cfg_len_we = 1'b1; cfg_case = 2'(slot); cfg_len = 4'(len);
        tick();
        cfg_len_we = 1'b0;
        chk("cfg_err_len", 64'(cfg_err), 64'(len > MAX_LEN));
        if (len <= MAX_LEN) m_len[slot] = len;
    endtask

    task automatic wr_step(input int slot, input int step, input int op, input logic [31:0] imm,
                           input bit use_imm, input bit ff);
        cfg_step_we = 1'b1; cfg_case = 2'(slot); cfg_step = 3'(step);
        cfg_op = op_t'(4'(op)); cfg_imm = imm; cfg_use_imm = use_imm; cfg_ff = ff;
        tick();
        cfg_step_we = 1'b0;
        chk("cfg_err_step", 64'(cfg_err), 0);
        m_op[slot][step] = 4'(op); m_imm[slot][step] = imm;
        m_use[slot][step] = use_imm; m_ff[slot][step] = ff;
    endtask

    task automatic drain();
        uop_ready = 1'b1;
        for (int i = 0; i < 40 && !req_ready; i++) tick();
        chk("drain_idle", 64'(req_ready), 1);
    endtask

    // Expected stream: each step in order, with a bubble after every ff step except the last.
    task automatic run_seq(input int slot, input int tag, input int rdy_pct, input int stall_step,
                           input int stall_n, output int span);
        int q[$];
        int len;
        int stall;
        len = m_len[slot];
        stall = stall_n;
        for (int k = 0; k < len; k++) begin
            q.push_back(k);
            if (m_ff[slot][k] && k != len - 1) q.push_back(-1);
        end
        chk("req_ready_idle", 64'(req_ready), 1);
        req_valid = 1'b1; req_case = 2'(slot); req_tag = 4'(tag);
        tick();
        req_valid = 1'b0;
        span = 1;
        if (len == 0) begin
            chk("req_err_empty", 64'(req_err), 1);
            chk("no_uop_empty", 64'(uop_valid), 0);
            chk("idle_after_empty", 64'(req_ready), 1);
            return;
        end
        chk("req_err_clear", 64'(req_err), 0);
        while (q.size() > 0 && span < 200) begin
            int it;
            it = q[0];
            if (it < 0) begin
                chk("bubble_valid", 64'(uop_valid), 0);
                chk("bubble_busy", 64'(busy), 1);
                uop_ready = 1'($urandom_range(1));
                void'(q.pop_front());
            end else begin
                if (it == stall_step && stall > 0) begin
                    uop_ready = 1'b0;
                    stall--;
                end else begin
                    uop_ready = ($urandom_range(99) < rdy_pct);
                end
                chk("uop_valid", 64'(uop_valid), 1);
                chk("uop_op", 64'(uop_op), 64'(m_op[slot][it]));
                chk("uop_imm", 64'(uop_imm), 64'(m_imm[slot][it]));
                chk("uop_use_imm", 64'(uop_use_imm), 64'(m_use[slot][it]));
                chk("uop_step", 64'(uop_step), 64'(it));
                chk("uop_first", 64'(uop_first), 64'(it == 0));
                chk("uop_last", 64'(uop_last), 64'(it == len - 1));
                chk("uop_tag", 64'(uop_tag), 64'(tag));
                chk("req_ready_busy", 64'(req_ready), 0);
                if (uop_ready) void'(q.pop_front());
            end
            tick();
            span++;
        end
        chk("seq_complete", 64'(q.size()), 0);
        chk("req_ready_after", 64'(req_ready), 1);
        chk("valid_after", 64'(uop_valid), 0);
        chk("busy_after", 64'(busy), 0);
    endtask

    initial begin
        int span;
        rst = 1'b1; cfg_len_we = 1'b0; cfg_step_we = 1'b0; cfg_case = '0; cfg_step = '0;
        cfg_len = '0; cfg_op = OP_NOP; cfg_imm = '0; cfg_use_imm = 1'b0; cfg_ff = 1'b0;
        req_valid = 1'b0; req_case = '0; req_tag = '0; uop_ready = 1'b0;
        for (int s = 0; s < N_CASE; s++) m_len[s] = 0;
        repeat (3) tick();
        chk("rst_req_ready", 64'(req_ready), 0);
        chk("rst_uop_valid", 64'(uop_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_cfg_err", 64'(cfg_err), 0);
        chk("rst_req_err", 64'(req_err), 0);
        rst = 1'b0;
        #1;
        chk("req_ready_post_rst", 64'(req_ready), 1);

        // Empty slot right after reset, then an oversize length that must not land.
        run_seq(0, 1, 100, -1, 0, span);
        wr_len(0, MAX_LEN + 1);
        run_seq(0, 2, 100, -1, 0, span);

        vecs[0] = '{1, 2, 'h00, 3, int'(OP_AND), 0, 3};
        vecs[1] = '{2, 3, 'h01, 5, int'(OP_DEC), 1, 5};
        vecs[2] = '{0, 1, 'h01, 1, int'(OP_ADD), 0, 2};
        vecs[3] = '{3, 8, 'h80, 7, int'(OP_NOP), 1, 9};
        vecs[4] = '{3, 8, 'h55, 9, int'(OP_XOR), 2, 13};
        vecs[5] = '{0, 4, 'h0F, 15, int'(OP_SUB), 3, 8};
        vecs[6] = '{2, 0, 'h00, 2, int'(OP_NOP), 0, 1};
        for (int i = 0; i < 7; i++) begin
            wr_len(vecs[i].slot, vecs[i].len);
            for (int k = 0; k < MAX_LEN; k++) begin
                wr_step(vecs[i].slot, k, (vecs[i].op0 + vecs[i].op_inc * k) % 12,
                        32'h10 * 32'(k + 1), (k % 2) == 0, vecs[i].ff[k]);
            end
            run_seq(vecs[i].slot, vecs[i].tag, 100, -1, 0, span);
            chk($sformatf("span_vec%0d", i), 64'(span), 64'(vecs[i].exp_span));
        end

        // Backpressure: step 1 of slot 3 held for five cycles.
        run_seq(3, 4, 100, 1, 5, span);
        chk("span_stall", 64'(span), 13 + 5);

        // Writes while slot 3 is in flight: slot 3 rejected, slot 0 accepted.
        req_valid = 1'b1; req_case = 2'd3; req_tag = 4'd6; uop_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        cfg_len_we = 1'b1; cfg_case = 2'd3; cfg_len = 4'd2;
        tick();
        cfg_len_we = 1'b0;
        chk("cfg_err_locked", 64'(cfg_err), 1);
        cfg_len_we = 1'b1; cfg_step_we = 1'b1; cfg_case = 2'd0; cfg_len = 4'd2;
        cfg_step = 3'd0; cfg_op = OP_MOV; cfg_imm = 32'hABCD; cfg_use_imm = 1'b1; cfg_ff = 1'b0;
        tick();
        cfg_len_we = 1'b0; cfg_step_we = 1'b0;
        chk("cfg_err_other", 64'(cfg_err), 0);
        m_len[0] = 2; m_op[0][0] = 4'(OP_MOV); m_imm[0][0] = 32'hABCD;
        m_use[0][0] = 1'b1; m_ff[0][0] = 1'b0;
        drain();
        run_seq(0, 8, 100, -1, 0, span);
        chk("span_slot0_new", 64'(span), 3);

        // Write to slot 1 in the acceptance cycle: the request sees the old step 0.
        req_valid = 1'b1; req_case = 2'd1; req_tag = 4'd10; uop_ready = 1'b0;
        cfg_step_we = 1'b1; cfg_case = 2'd1; cfg_step = 3'd0; cfg_op = OP_OR;
        cfg_imm = 32'h55; cfg_use_imm = 1'b0; cfg_ff = 1'b0;
        tick();
        req_valid = 1'b0; cfg_step_we = 1'b0;
        chk("same_cycle_op", 64'(uop_op), 64'(m_op[1][0]));
        chk("same_cycle_imm", 64'(uop_imm), 64'(m_imm[1][0]));
        chk("same_cycle_cfg_err", 64'(cfg_err), 0);
        m_op[1][0] = 4'(OP_OR); m_imm[1][0] = 32'h55; m_use[1][0] = 1'b0; m_ff[1][0] = 1'b0;
        drain();
        run_seq(1, 11, 100, -1, 0, span);

        for (int it = 0; it < 40; it++) begin
            int s;
            s = int'($urandom_range(N_CASE - 1));
            if ($urandom_range(2) == 0) wr_len(s, int'($urandom_range(MAX_LEN + 1)));
            repeat ($urandom_range(3)) begin
                wr_step(s, int'($urandom_range(MAX_LEN - 1)), int'($urandom_range(11)),
                        $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
            end
            run_seq(int'($urandom_range(N_CASE - 1)), int'($urandom_range(15)),
                    int'($urandom_range(100, 40)), -1, 0, span);
        end

        // Reset while step 1 is presented abandons the sequence and clears all lengths.
        wr_len(3, 4);
        req_valid = 1'b1; req_case = 2'd3; req_tag = 4'd12; uop_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        if (m_ff[3][0]) tick();
        tick();
        uop_ready = 1'b0;
        chk("pre_rst_valid", 64'(uop_valid), 1);
        chk("pre_rst_step", 64'(uop_step), 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 64'(uop_valid), 0);
        chk("mid_rst_ready", 64'(req_ready), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(req_ready), 1);
        chk("post_rst_busy", 64'(busy), 0);
        tick();
        chk("post_rst_no_uop", 64'(uop_valid), 0);
        for (int s = 0; s < N_CASE; s++) m_len[s] = 0;
        for (int s = 0; s < N_CASE; s++) run_seq(s, s, 100, -1, 0, span);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uop_seq_issuer.md
# uop_seq_issuer

Runtime-programmable micro-op sequence issuer, the parametrised successor to the static fused-op length tables. It holds N_CASE sequences of up to MAX_LEN uops (op, immediate, use-immediate flag, per-step flip-flop boundary) in a writable table. On request it streams the selected sequence one uop per handshake to the execute pipeline, inserting a one-cycle bubble at every flip-flop boundary. It sits between custom-instruction decode and the uop execute stage.

## Interface
- N_CASE, 4, number of sequence slots
- MAX_LEN, 8, maximum uops per sequence (≥1)
- TAG_W, 4, width of the request tag carried through to each uop
- Derived: CASE_W = $clog2(N_CASE) (min 1), STEP_W = $clog2(MAX_LEN) (min 1), LEN_W = $clog2(MAX_LEN+1)

- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_len_we  in  1  write cfg_len into slot cfg_case
- cfg_step_we  in  1  write step fields into slot cfg_case, step cfg_step
- cfg_case  in  CASE_W  target slot
- cfg_step  in  STEP_W  target step
- cfg_len  in  LEN_W  sequence length
- cfg_op  in  op_t (uop_pkg)  step opcode
- cfg_imm  in  32  step immediate
- cfg_use_imm  in  1  step uses immediate
- cfg_ff  in  1  register boundary after this step
- cfg_err  out  1  one-cycle pulse: rejected config write
- req_valid  in  1  sequence request
- req_ready  out  1  issuer idle, accepting
- req_case  in  CASE_W  slot to issue
- req_tag  in  TAG_W  tag echoed on all uops
- req_err  out  1  one-cycle pulse: request accepted for empty slot
- uop_valid  out  1  uop presented
- uop_ready  in  1  downstream accepts
- uop_op  out  op_t  opcode
- uop_imm  out  32  immediate
- uop_use_imm  out  1  use-immediate flag
- uop_step  out  STEP_W  index within sequence
- uop_first  out  1  step 0
- uop_last  out  1  final step
- uop_tag  out  TAG_W  request tag
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, ISSUE, BUBBLE.
- IDLE: req_ready=1. On req_valid: latch case, tag, len. If len==0: pulse req_err next cycle, stay IDLE. Otherwise step=0, go to ISSUE.
- ISSUE: uop_valid=1; fields come from table[case][step]. Fields are held stable until uop_ready.
  - On handshake with step==len-1: go to IDLE.
  - On handshake with ff[step]==1: step++, go to BUBBLE.
  - On any other handshake: step++, stay ISSUE.
- BUBBLE: uop_valid=0 for exactly one cycle, then ISSUE. A ff bit on the last step is ignored (no trailing bubble).
- Config writes:
  - Take effect the cycle after the write.
  - cfg_len > MAX_LEN is rejected (cfg_err, no write).
  - Any write to the slot latched by an in-flight sequence (busy && cfg_case==active case) is rejected (cfg_err).
  - Simultaneous cfg_len_we and cfg_step_we are both performed.
  - A config write in the same cycle as a request acceptance for the same slot: the request sees the pre-write contents.
- Reset:
  - All slot lengths clear to 0. Step fields are not reset.
  - FSM → IDLE. uop_valid, busy, cfg_err, req_err = 0.
  - Reset mid-sequence abandons it; no further uops are issued.

## Timing
- req_ready is combinational: (state==IDLE) && !rst. It is 1 in the first cycle after reset deasserts.
- Request accepted in cycle t → first uop valid in cycle t+1.
- Without bubbles, step k+1 is valid the cycle after step k's handshake when uop_ready is held high (1 uop/cycle).
- Each ff boundary adds one cycle.
- After the last handshake, req_ready is 1 the next cycle. Minimum request-to-request spacing is len+1+(#ff bits on non-last steps) cycles.
- cfg_err and req_err are registered, one cycle after the causing event.
- uop_* fields are registered. They are don't-care when uop_valid=0.

## Test plan
- Load slot 1: len=2, steps {OP_AND, OP_AND}, ff=0. Request case 1, tag 3, uop_ready=1 → valid at t+1 and t+2, step 0 first=1, step 1 last=1, tag=3. req_ready returns at t+3.
- Load slot 2: len=3, ff on step 0 (OP_DEC, imm 0x10, use_imm=1). Request → step 0 at t+1, bubble at t+2, steps 1–2 at t+3/t+4. Step 0 shows imm=0x10 and use_imm=1.
- Backpressure: hold uop_ready=0 for 5 cycles on step 1 → uop_op, uop_step and uop_tag stay stable. Sequence resumes on release.
- Right after reset, request slot 0 → req_err pulses and no uop_valid is issued. Writing cfg_len=MAX_LEN+1 → cfg_err and the length is unchanged.
- During an active slot-3 sequence, write slot 3 → cfg_err. Write slot 0 → accepted and visible on the next slot-0 request.
- Assert rst while step 1 is valid → uop_valid=0 the next cycle, then req_ready=1 and all slots have len 0.
